vram_arbiter: RTL and testbench

Sequences and shares a single read/write port of the video memory between two requesters: the Z80 bus interface (single-word reads/writes) and the display fetcher (fixed-length read bursts). The display has priority so scanline fetches meet their deadline. A wait counter guarantees the CPU a slot after MAXWAIT cycles of denial. The block sits between the Z80 bus glue and the memory port, in the same clock domain as that port.

---
 rtl/vram_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_vram_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one read/write port of the video memory between the
// Z80 bus interface (single-word accesses) and the display fetcher
// (fixed-length read bursts). The display has priority so scanline fetches
// meet their deadline; a saturating wait counter lets a CPU request that has
// been denied for MAXWAIT cycles win the next arbitration. A burst is never
// preempted.
//
// Memory port timing: mem_rdata is valid the cycle after mem_re.
//   CPU access : grant (IDLE) -> CPU_ISSUE (N) -> CPU_RESP (N+1) -> ack in N+2
//   Burst      : grant (IDLE) -> DISP_ISSUE x BURST -> DISP_DRAIN -> IDLE
//                word issued in cycle M appears on disp_data in cycle M+2
module vram_arbiter #(
  parameter int DATA    = 8,
  parameter int ADDR    = 16,
  parameter int BURST   = 8,
  parameter int MAXWAIT = 16
) (
  input  logic            clk,
  input  logic            rst_L,
  // Z80 bus interface
  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic [ADDR-1:0] cpu_addr,
  input  logic [DATA-1:0] cpu_wdata,
  output logic            cpu_ack,
  output logic [DATA-1:0] cpu_rdata,
  // display fetcher
  input  logic            disp_req,
  input  logic [ADDR-1:0] disp_base,
  output logic            disp_valid,
  output logic [DATA-1:0] disp_data,
  output logic            disp_done,
  // memory port
  output logic [ADDR-1:0] mem_addr,
  output logic            mem_we,
  output logic            mem_re,
  output logic [DATA-1:0] mem_wdata,
  input  logic [DATA-1:0] mem_rdata
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_CPU_ISSUE  = 3'd1;
  localparam logic [2:0] S_CPU_RESP   = 3'd2;
  localparam logic [2:0] S_DISP_ISSUE = 3'd3;
  localparam logic [2:0] S_DISP_DRAIN = 3'd4;

  localparam int IDX_W  = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int WAIT_W = $clog2(MAXWAIT + 1);

  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(BURST - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAXWAIT);

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [ADDR-1:0]   base;
  logic [WAIT_W-1:0] wait_cnt;

  logic cpu_rd_pend;   // CPU read issued last cycle, data on mem_rdata now
  logic disp_rd_pend;  // burst word issued last cycle, data on mem_rdata now
  logic disp_last_pend;

  logic cpu_req_eff;
  logic disp_req_eff;
  logic cpu_starved;
  logic cpu_busy;
  logic grant_cpu;
  logic grant_disp;

  // A requester drops its request in the cycle its own completion pulse is
  // high, so the level seen in that cycle is stale and must not be granted.
  assign cpu_req_eff  = cpu_req  & ~cpu_ack;
  assign disp_req_eff = disp_req & ~disp_done;
  assign cpu_starved  = cpu_req_eff & (wait_cnt == WAIT_MAX);
  assign cpu_busy     = (state == S_CPU_ISSUE) || (state == S_CPU_RESP);

  assign grant_disp = (state == S_IDLE) && disp_req_eff && !cpu_starved;
  assign grant_cpu  = (state == S_IDLE) && !grant_disp && cpu_req_eff;

  // Next-state decode: arbitration in IDLE, fixed sequencing elsewhere.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first; a path that leaves it unassigned would infer a latch.
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (grant_disp)     state_nxt = S_DISP_ISSUE;
        else if (grant_cpu) state_nxt = S_CPU_ISSUE;
      end
      S_CPU_ISSUE:  state_nxt = S_CPU_RESP;
      S_CPU_RESP:   state_nxt = S_IDLE;
      S_DISP_ISSUE: if (idx == IDX_LAST) state_nxt = S_DISP_DRAIN;
      S_DISP_DRAIN: state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  // State register, burst base latch and burst word index.
  always_ff @(posedge clk or negedge rst_L) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block evaluation order.
    if (!rst_L) begin
      state <= S_IDLE;
      idx   <= '0;
      base  <= '0;
    end else begin
      state <= state_nxt;
      if (grant_disp) begin
        base <= disp_base;
        idx  <= '0;
      end else if (state == S_DISP_ISSUE) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
    end
  end

  // Memory port drive: decoded from state so a reset clears it at once.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_wdata = '0;
    case (state)
      S_CPU_ISSUE: begin
        mem_addr  = cpu_addr;
        mem_we    = cpu_we;
        mem_re    = ~cpu_we;
        mem_wdata = cpu_wdata;
      end
      S_DISP_ISSUE: begin
        // Address arithmetic is ADDR bits wide, so the burst wraps at the top.
        mem_addr = base + ADDR'(idx);
        mem_re   = 1'b1;
      end
      default: ;
    endcase
  end

  // CPU denial counter: counts pending, unserved CPU cycles; saturates.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      wait_cnt <= '0;
    end else if (grant_cpu) begin
      wait_cnt <= '0;
    end else if (cpu_req_eff && !cpu_busy && (wait_cnt != WAIT_MAX)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // CPU response: capture read data and pulse ack one cycle after issue+1.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      cpu_rd_pend <= 1'b0;
      cpu_ack     <= 1'b0;
      cpu_rdata   <= '0;
    end else begin
      cpu_rd_pend <= (state == S_CPU_ISSUE) && !cpu_we;
      cpu_ack     <= (state == S_CPU_RESP);
      if (cpu_rd_pend) cpu_rdata <= mem_rdata;
    end
  end

  // Display return path: two-stage pipeline from issue to disp_data.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      disp_rd_pend   <= 1'b0;
      disp_last_pend <= 1'b0;
      disp_valid     <= 1'b0;
      disp_done      <= 1'b0;
      disp_data      <= '0;
    end else begin
      disp_rd_pend   <= (state == S_DISP_ISSUE);
      disp_last_pend <= (state == S_DISP_ISSUE) && (idx == IDX_LAST);
      disp_valid     <= disp_rd_pend;
      disp_done      <= disp_last_pend;
      if (disp_rd_pend) disp_data <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed scenarios plus randomized traffic for
// vram_arbiter. A schedule-based reference model predicts every output for
// every cycle; the bench also owns the memory behind the port.
module tb_vram_arbiter;

  localparam int DATA    = 8;
  localparam int ADDR    = 16;
  localparam int BURST   = 8;
  localparam int MAXWAIT = 16;
  localparam int RING    = 64;

  logic            clk;
  logic            rst_L;
  logic            cpu_req;
  logic            cpu_we;
  logic [ADDR-1:0] cpu_addr;
  logic [DATA-1:0] cpu_wdata;
  logic            cpu_ack;
  logic [DATA-1:0] cpu_rdata;
  logic            disp_req;
  logic [ADDR-1:0] disp_base;
  logic            disp_valid;
  logic [DATA-1:0] disp_data;
  logic            disp_done;
  logic [ADDR-1:0] mem_addr;
  logic            mem_we;
  logic            mem_re;
  logic [DATA-1:0] mem_wdata;
  logic [DATA-1:0] mem_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  vram_arbiter #(
    .DATA(DATA), .ADDR(ADDR), .BURST(BURST), .MAXWAIT(MAXWAIT)
  ) dut (
    .clk(clk), .rst_L(rst_L),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .disp_req(disp_req), .disp_base(disp_base), .disp_valid(disp_valid),
    .disp_data(disp_data), .disp_done(disp_done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Initial memory contents, known to both the memory and the model.
  function automatic logic [7:0] init_val(input logic [15:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    if (a >= 16'h2000 && a <= 16'h2007) return 8'h10 + lo;
    if (a == 16'h0100) return 8'hC3;
    return a[15:8] ^ (lo * 8'd7) ^ 8'h5A;
  endfunction

  // Memory behind the port: synchronous write, one-cycle read latency.
  logic [7:0] sim_mem [65536];
  initial begin : memory
    for (int i = 0; i < 65536; i++) sim_mem[i] = init_val(16'(i));
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (mem_we) sim_mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= sim_mem[mem_addr];
    end
  end

  // Reference model: when the port is free, grants reserve a fixed window of
  // future cycles and write the expected outputs into a ring of slots.
  typedef struct packed {
    logic        re;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        ack;
    logic        ack_rd;
    logic [7:0]  rdata;
    logic        dvalid;
    logic        ddone;
    logic [7:0]  ddata;
  } slot_t;

  slot_t      slots [RING];
  logic [7:0] ref_mem [65536];

  initial begin : model
    int t, free_at, m_wait, cpu_svc_end, s;
    logic [7:0] exp_rdata;
    logic [15:0] a;
    slot_t e;
    bit cpu_eff, disp_eff, cpu_grant;
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(16'(i));
    for (int i = 0; i < RING; i++) slots[i] = '0;
    t = 0; free_at = 0; m_wait = 0; cpu_svc_end = -1; exp_rdata = '0;
    forever begin
      @(negedge clk);
      t++;
      s = t % RING;
      if (!rst_L) begin
        for (int i = 0; i < RING; i++) slots[i] = '0;
        free_at = 0; m_wait = 0; cpu_svc_end = -1; exp_rdata = '0;
        check($sformatf("c%0d rst mem_re", t), mem_re, 0);
        check($sformatf("c%0d rst mem_we", t), mem_we, 0);
        check($sformatf("c%0d rst mem_addr", t), mem_addr, 0);
        check($sformatf("c%0d rst cpu_ack", t), cpu_ack, 0);
        check($sformatf("c%0d rst cpu_rdata", t), cpu_rdata, 0);
        check($sformatf("c%0d rst disp_valid", t), disp_valid, 0);
        check($sformatf("c%0d rst disp_done", t), disp_done, 0);
        check($sformatf("c%0d rst disp_data", t), disp_data, 0);
      end else begin
        e = slots[s];
        slots[s] = '0;
        if (e.ack && e.ack_rd) exp_rdata = e.rdata;
        check($sformatf("c%0d mem_re", t), mem_re, e.re);
        check($sformatf("c%0d mem_we", t), mem_we, e.we);
        if (e.re || e.we) check($sformatf("c%0d mem_addr", t), mem_addr, e.addr);
        if (e.we) check($sformatf("c%0d mem_wdata", t), mem_wdata, e.wdata);
        check($sformatf("c%0d cpu_ack", t), cpu_ack, e.ack);
        check($sformatf("c%0d cpu_rdata", t), cpu_rdata, exp_rdata);
        check($sformatf("c%0d disp_valid", t), disp_valid, e.dvalid);
        check($sformatf("c%0d disp_done", t), disp_done, e.ddone);
        if (e.dvalid) check($sformatf("c%0d disp_data", t), disp_data, e.ddata);

        cpu_eff   = cpu_req && !e.ack;
        disp_eff  = disp_req && !e.ddone;
        cpu_grant = 1'b0;
        if (t >= free_at) begin
          if (disp_eff && !(cpu_eff && m_wait == MAXWAIT)) begin
            for (int i = 0; i < BURST; i++) begin
              a = disp_base + 16'(i);
              slots[(t + 1 + i) % RING].re     = 1'b1;
              slots[(t + 1 + i) % RING].addr   = a;
              slots[(t + 3 + i) % RING].dvalid = 1'b1;
              slots[(t + 3 + i) % RING].ddata  = ref_mem[a];
            end
            slots[(t + 2 + BURST) % RING].ddone = 1'b1;
            free_at = t + BURST + 2;
          end else if (cpu_eff) begin
            cpu_grant = 1'b1;
            slots[(t + 1) % RING].we    = cpu_we;
            slots[(t + 1) % RING].re    = !cpu_we;
            slots[(t + 1) % RING].addr  = cpu_addr;
            slots[(t + 1) % RING].wdata = cpu_wdata;
            if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
            slots[(t + 3) % RING].ack    = 1'b1;
            slots[(t + 3) % RING].ack_rd = !cpu_we;
            slots[(t + 3) % RING].rdata  = ref_mem[cpu_addr];
            free_at = t + 3;
            cpu_svc_end = t + 2;
          end
        end
        if (cpu_grant) m_wait = 0;
        else if (cpu_eff && t > cpu_svc_end && m_wait < MAXWAIT) m_wait++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_gap(input int n);
    cpu_req = 1'b0;
    disp_req = 1'b0;
    repeat (n) step();
  endtask

  // Counts cycles from the current one (0) until cpu_ack, bounded.
  task automatic wait_cpu_ack(output int lat);
    lat = 0;
    @(negedge clk);
    while (!cpu_ack && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    check("cpu_ack_seen", cpu_ack, 1);
  endtask

  initial begin : stimulus
    int lat, nv, nre, nd;
    logic [7:0]  done_word;
    logic [15:0] wa [8];
    logic [31:0] r;
    bit ack_seen, done_seen;

    rst_L = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    disp_req = 1'b0; disp_base = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset mem_re", mem_re, 0);
    check("reset cpu_ack", cpu_ack, 0);
    check("reset disp_valid", disp_valid, 0);
    step();
    rst_L = 1'b1;
    idle_gap(3);

    // CPU write 0x5A -> 0x1234 from idle
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'h5A;
    @(negedge clk);
    check("wr grant mem_we", mem_we, 0);
    step();
    @(negedge clk);
    check("wr N mem_we", mem_we, 1);
    check("wr N mem_re", mem_re, 0);
    check("wr N mem_addr", mem_addr, 16'h1234);
    check("wr N mem_wdata", mem_wdata, 8'h5A);
    step();
    @(negedge clk);
    check("wr N+1 cpu_ack", cpu_ack, 0);
    step();
    @(negedge clk);
    check("wr N+2 cpu_ack", cpu_ack, 1);
    step();
    idle_gap(4);

    // Burst from 0x2000: words 0x10..0x17
    disp_req = 1'b1; disp_base = 16'h2000;
    step();
    disp_req = 1'b0;
    nv = 0; nre = 0; nd = 0; done_word = '0;
    repeat (14) begin
      @(negedge clk);
      if (mem_re) nre++;
      if (disp_valid) begin
        check($sformatf("burst word%0d", nv), disp_data, 8'h10 + nv);
        nv++;
      end
      if (disp_done) begin nd++; done_word = disp_data; end
    end
    check("burst valid count", nv, BURST);
    check("burst mem_re count", nre, BURST);
    check("burst done count", nd, 1);
    check("burst done word", done_word, 8'h17);
    step();
    idle_gap(4);

    // Burst wrapping at the top of the address space
    disp_req = 1'b1; disp_base = 16'hFFFE;
    step();
    disp_req = 1'b0;
    nre = 0;
    repeat (12) begin
      @(negedge clk);
      if (mem_re && nre < 8) begin wa[nre] = mem_addr; nre++; end
    end
    check("wrap count", nre, BURST);
    check("wrap addr0", wa[0], 16'hFFFE);
    check("wrap addr1", wa[1], 16'hFFFF);
    check("wrap addr2", wa[2], 16'h0000);
    check("wrap addr3", wa[3], 16'h0001);
    step();
    idle_gap(4);

    // Simultaneous requests, wait counter at 0: display first
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100;
    disp_req = 1'b1; disp_base = 16'h3000;
    @(negedge clk);
    step();
    disp_req = 1'b0;
    @(negedge clk);
    check("simul first re", mem_re, 1);
    check("simul first addr", mem_addr, 16'h3000);
    lat = 1;
    while (!cpu_ack && lat < 300) begin @(negedge clk); lat++; end
    check("simul cpu_ack_seen", cpu_ack, 1);
    check("simul cpu latency", lat, BURST + 5);
    check("simul cpu_rdata", cpu_rdata, 8'hC3);
    step();
    idle_gap(4);

    // Display held continuously while the CPU waits
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2003;
    disp_req = 1'b1; disp_base = 16'h2000;
    wait_cpu_ack(lat);
    check("held cpu latency", lat, BURST + 5);
    check("held cpu_rdata", cpu_rdata, 8'h13);
    step();
    cpu_req = 1'b0;
    nv = 0;
    repeat (12) begin
      @(negedge clk);
      if (disp_valid) nv++;
    end
    check("held display resumes", nv, BURST);
    step();
    idle_gap(20);

    // Reset in the 3rd cycle of a burst
    disp_req = 1'b1; disp_base = 16'h2000;
    step();
    disp_req = 1'b0;
    step();
    @(posedge clk);
    #2;
    check("pre-rst mem_re", mem_re, 1);
    check("pre-rst mem_addr", mem_addr, 16'h2002);
    rst_L = 1'b0;
    #1;
    check("async rst mem_re", mem_re, 0);
    check("async rst mem_addr", mem_addr, 0);
    check("async rst disp_valid", disp_valid, 0);
    nd = 0; nv = 0;
    repeat (2) begin
      @(negedge clk);
      if (disp_done) nd++;
    end
    step();
    rst_L = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (disp_done) nd++;
      if (disp_valid) nv++;
    end
    check("rst no disp_done", nd, 0);
    check("rst no disp_valid", nv, 0);
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100;
    wait_cpu_ack(lat);
    check("post-rst cpu latency", lat, 3);
    check("post-rst cpu_rdata", cpu_rdata, 8'hC3);
    step();
    idle_gap(4);

    // Randomized traffic, checked cycle by cycle by the model
    for (int k = 0; k < 2500; k++) begin
      @(negedge clk);
      ack_seen  = cpu_ack;
      done_seen = disp_done;
      step();
      if (cpu_req && ack_seen) cpu_req = 1'b0;
      if (!cpu_req && $urandom_range(0, 2) == 0) begin
        r = $urandom;
        cpu_req   = 1'b1;
        cpu_we    = r[5];
        cpu_wdata = r[13:6];
        cpu_addr  = r[0] ? {12'h010, r[4:1]} : r[31:16];
      end
      if (disp_req && done_seen && $urandom_range(0, 1) == 0) begin
        disp_req = 1'b0;
      end else if (!disp_req && $urandom_range(0, 5) == 0) begin
        r = $urandom;
        disp_req  = 1'b1;
        disp_base = r[2] ? (16'hFFFC + 16'(r[1:0])) : {4'h0, r[15:4]};
      end
    end
    cpu_req = 1'b0;
    disp_req = 1'b0;
    repeat (40) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
